write_resp_router: RTL

- B-channel return path of the AXI interconnect; counterpart of the write-data steering queue.
- Records {master, slave} for every granted AW and tracks write-data completion per entry.
- Accepts each slave's B response in strict AW-grant order, once that entry's write data has finished.
- Returns the response to the originating master with a registered VALID/READY handshake.

---
 rtl/write_resp_router_if.sv | 34 +++
 rtl/write_resp_router.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/write_resp_router_if.sv
// Write-response routing bus: AW/W bookkeeping inputs, queue status and both B-channel sides.
// The router connects through the slave modport; the surrounding fabric uses master.
interface write_resp_router_if #(
    parameter int Masters_Num = 2,
    parameter int Slaves_Num  = 2
);
    localparam int MID = $clog2(Masters_Num);
    localparam int SID = $clog2(Slaves_Num);

    logic                    AW_Access_Grant;
    logic [MID-1:0]          AW_Master_ID;
    logic [SID-1:0]          AW_Slave_ID;
    logic                    Write_Data_Finsh;
    logic                    Queue_Is_Full;
    logic                    Queue_Is_Empty;
    logic [Slaves_Num-1:0]   S_BVALID;
    logic [2*Slaves_Num-1:0] S_BRESP;
    logic [Slaves_Num-1:0]   S_BREADY;
    logic [Masters_Num-1:0]  M_BVALID;
    logic [1:0]              M_BRESP;
    logic [Masters_Num-1:0]  M_BREADY;

    modport slave (
        input  AW_Access_Grant, AW_Master_ID, AW_Slave_ID, Write_Data_Finsh,
        input  S_BVALID, S_BRESP, M_BREADY,
        output Queue_Is_Full, Queue_Is_Empty, S_BREADY, M_BVALID, M_BRESP
    );

    modport master (
        output AW_Access_Grant, AW_Master_ID, AW_Slave_ID, Write_Data_Finsh,
        output S_BVALID, S_BRESP, M_BREADY,
        input  Queue_Is_Full, Queue_Is_Empty, S_BREADY, M_BVALID, M_BRESP
    );
endinterface

// File: rtl/write_resp_router.sv
// B-channel return path: queues {master, slave} per granted AW and forwards each slave's
// write response to its master in AW-grant order once that entry's write data is done.
module write_resp_router #(
    parameter int Masters_Num = 2,
    parameter int Slaves_Num  = 2,
    parameter int Depth       = 4
) (
    input  logic ACLK,
    input  logic ARESETN,
    write_resp_router_if.slave bus
);
    localparam int MID = $clog2(Masters_Num);
    localparam int SID = $clog2(Slaves_Num);
    localparam int AW  = $clog2(Depth);

    typedef enum logic [1:0] {IDLE, WAIT_RESP, SEND_RESP} state_t;

    logic [MID-1:0] mid_q [Depth];
    logic [SID-1:0] sid_q [Depth];

    logic [AW:0] wp_q, wp_d;
    logic [AW:0] dp_q, dp_d;
    logic [AW:0] rp_q, rp_d;
    logic [AW:0] rp_inc;

    state_t                 state_q;
    logic [1:0]             resp_q;
    logic [Slaves_Num-1:0]  s_bready_q;
    logic [Masters_Num-1:0] m_bvalid_q;

    logic           full, empty, push, data_done, pop, eligible;
    logic [MID-1:0] head_mid;
    logic [SID-1:0] head_sid;
    logic [SID-1:0] next_sid;

    function automatic logic [Slaves_Num-1:0] onehot_s(input logic [SID-1:0] idx);
        logic [Slaves_Num-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [Masters_Num-1:0] onehot_m(input logic [MID-1:0] idx);
        logic [Masters_Num-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty     = (wp_q == rp_q);
    assign push      = bus.AW_Access_Grant && !full;
    assign data_done = bus.Write_Data_Finsh && (dp_q != wp_q);
    assign eligible  = (rp_q != dp_q);
    assign rp_inc    = rp_q + (AW+1)'(1);

    assign head_mid = mid_q[rp_q[AW-1:0]];
    assign head_sid = sid_q[rp_q[AW-1:0]];
    assign next_sid = sid_q[rp_inc[AW-1:0]];

    assign pop = (state_q == SEND_RESP) && bus.M_BREADY[head_mid];

    always_comb begin
        wp_d = wp_q;
        dp_d = dp_q;
        rp_d = rp_q;
        if (push)      wp_d = wp_q + (AW+1)'(1);
        if (data_done) dp_d = dp_q + (AW+1)'(1);
        if (pop)       rp_d = rp_inc;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wp_q <= '0;
            dp_q <= '0;
            rp_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mid_q[i] <= '0;
                sid_q[i] <= '0;
            end
        end else begin
            wp_q <= wp_d;
            dp_q <= dp_d;
            rp_q <= rp_d;
            if (push) begin
                mid_q[wp_q[AW-1:0]] <= bus.AW_Master_ID;
                sid_q[wp_q[AW-1:0]] <= bus.AW_Slave_ID;
            end
        end
    end

    // Handshake outputs are registered so S_BVALID never reaches M_BVALID combinationally.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            resp_q     <= 2'b00;
            s_bready_q <= '0;
            m_bvalid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eligible) begin
                        state_q    <= WAIT_RESP;
                        s_bready_q <= onehot_s(head_sid);
                    end
                end
                WAIT_RESP: begin
                    if (bus.S_BVALID[head_sid]) begin
                        state_q    <= SEND_RESP;
                        resp_q     <= bus.S_BRESP[{head_sid, 1'b0} +: 2];
                        s_bready_q <= '0;
                        m_bvalid_q <= onehot_m(head_mid);
                    end
                end
                SEND_RESP: begin
                    if (pop) begin
                        m_bvalid_q <= '0;
                        // Chain straight into the next entry when its data is already done.
                        if (rp_inc != dp_q) begin
                            state_q    <= WAIT_RESP;
                            s_bready_q <= onehot_s(next_sid);
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    s_bready_q <= '0;
                    m_bvalid_q <= '0;
                end
            endcase
        end
    end

    assign bus.Queue_Is_Full  = full;
    assign bus.Queue_Is_Empty = empty;
    assign bus.S_BREADY       = s_bready_q;
    assign bus.M_BVALID       = m_bvalid_q;
    assign bus.M_BRESP        = resp_q;
endmodule
